// File: rtl/main_controller.sv
// Multicycle MIPS-subset main controller.
// One registered state code; every control output is decoded combinationally
// from the state, with a few strobes also depending on mem_ready, zero and
// the instruction fields. While rst_n is low the decode behaves as FETCH
// with both write strobes held off, whatever the state register holds.
module main_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic [2:0] alucont,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       mem_req,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_LBRD    = 4'd3,
        S_SBWR    = 4'd4,
        S_RTYPEEX = 4'd5,
        S_ADDIEX  = 4'd6,
        S_BEQEX   = 4'd7,
        S_JEX     = 4'd8
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Kept as a plain vector so the unused codes 9-15 are representable.
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_run_state;
    logic       w_funct_ok;
    logic [2:0] w_rtype_alu;
    logic       w_illegal;

    assign state = r_state;

    // While reset is held the output decode treats the block as sitting in FETCH.
    assign w_run_state = rst_n ? r_state : S_FETCH;

    // R-type funct decode: ALU operation and legality.
    always_comb begin
        w_funct_ok  = 1'b1;
        w_rtype_alu = 3'b010;
        case (funct)
            6'b100000: w_rtype_alu = 3'b010;
            6'b100010: w_rtype_alu = 3'b110;
            6'b100100: w_rtype_alu = 3'b000;
            6'b100101: w_rtype_alu = 3'b001;
            6'b101010: w_rtype_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    // Opcode legality as seen in DECODE.
    always_comb begin
        w_illegal = 1'b0;
        case (opcode)
            OP_LB, OP_SB, OP_ADDI, OP_BEQ, OP_J: w_illegal = 1'b0;
            OP_RTYPE: w_illegal = !w_funct_ok;
            default:  w_illegal = 1'b1;
        endcase
    end

    // Next-state logic; illegal instructions and unused codes fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LB, OP_SB: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = w_funct_ok ? S_RTYPEEX : S_FETCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:   w_next = mem_ready ? S_FETCH : S_LBRD;
            S_SBWR:   w_next = mem_ready ? S_FETCH : S_SBWR;
            default:  w_next = S_FETCH;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Control output decode from the effective state.
    always_comb begin
        alucont    = 3'b010;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pc_src     = 2'b00;
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        illegal_op = 1'b0;
        case (w_run_state)
            S_FETCH: begin
                mem_req  = 1'b1;
                iord     = 1'b0;
                ir_write = mem_ready & rst_n;
                pc_write = mem_ready & rst_n;
            end
            S_DECODE: begin
                illegal_op = w_illegal;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_LBRD, S_SBWR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                alucont = w_rtype_alu;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                alucont  = 3'b110;
                pc_src   = 2'b01;
                pc_write = zero;
            end
            S_JEX: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_main_controller.sv
// Bench for main_controller: per-cycle expected states are queued when the
// stimulus is planned, then popped and compared as the controller advances.
module tb_main_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] state;
    logic [2:0] alucont;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       mem_req;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       illegal_op;

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0]  exp_q[$];
    logic        mr_q[$];
    logic [11:0] op_q[$];

    main_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .state      (state),
        .alucont    (alucont),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .mem_req    (mem_req),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .illegal_op (illegal_op)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr);
        mem_ready = mr;
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1);
        n_total++;
        if (mem_req !== 1'b1 || iord !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0)
            begin n_bad++; $display("FAIL reset_pre_edge mem_req=%b iord=%b ir=%b pc=%b want 1 0 0 0", mem_req, iord, ir_write, pc_write); end
        tick();
        drive(1'b1);
        n_total++;
        if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state got=%0d want=0", state); end
        n_total++;
        if (mem_req !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0 || illegal_op !== 1'b0 || alucont !== 3'b010)
            begin n_bad++; $display("FAIL reset_outputs mem_req=%b ir=%b pc=%b ill=%b alu=%b", mem_req, ir_write, pc_write, illegal_op, alucont); end
        tick();
        rst_n = 1'b1;
        drive(1'b0);
        n_total++;
        if (state !== 4'd0 || mem_req !== 1'b1 || ir_write !== 1'b0)
            begin n_bad++; $display("FAIL reset_first_fetch state=%0d mem_req=%b ir=%b want 0 1 0", state, mem_req, ir_write); end
    endtask

    task automatic test_addi();
        logic [3:0] exp;
        opcode = 6'b001000; funct = 6'd0; zero = 1'b0;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd6); exp_q.push_back(4'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1);
            exp = exp_q.pop_front();
            n_total++;
            if (state !== exp) begin n_bad++; $display("FAIL addi_state cyc=%0d got=%0d want=%0d", i, state, exp); end
            if (i < 3) begin
                n_total++;
                if (ir_write !== (i == 0) || pc_write !== (i == 0))
                    begin n_bad++; $display("FAIL addi_writes cyc=%0d ir=%b pc=%b want=%b", i, ir_write, pc_write, (i == 0)); end
            end
            if (exp == 4'd6) begin
                n_total++;
                if (alusrca !== 1'b1 || alusrcb !== 2'b10 || alucont !== 3'b010)
                    begin n_bad++; $display("FAIL addi_ex srca=%b srcb=%b alu=%b want 1 10 010", alusrca, alusrcb, alucont); end
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_lb();
        logic [3:0] exp;
        logic       mr;
        logic       mrs[10];
        mrs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        mrs[3] = 1'($urandom_range(0, 1));
        mrs[4] = 1'($urandom_range(0, 1));
        opcode = 6'b100000; funct = 6'd0;
        exp_q.push_back(4'd0); exp_q.push_back(4'd0); exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd3); exp_q.push_back(4'd3);
        exp_q.push_back(4'd3); exp_q.push_back(4'd0);
        for (int i = 0; i < 10; i++) begin
            mr = mrs[i];
            drive(mr);
            exp = exp_q.pop_front();
            n_total++;
            if (state !== exp) begin n_bad++; $display("FAIL lb_state cyc=%0d got=%0d want=%0d", i, state, exp); end
            if (exp == 4'd3) begin
                n_total++;
                if (mem_req !== 1'b1 || iord !== 1'b1 || alusrcb !== 2'b10)
                    begin n_bad++; $display("FAIL lb_rd cyc=%0d mem_req=%b iord=%b srcb=%b", i, mem_req, iord, alusrcb); end
            end
            if (exp == 4'd0) begin
                n_total++;
                if (ir_write !== mr) begin n_bad++; $display("FAIL lb_fetch_ir cyc=%0d got=%b want=%b", i, ir_write, mr); end
            end
            if (i < 9) tick();
        end
    endtask

    task automatic test_rtype();
        logic [3:0] exp;
        logic [5:0] fn[3];
        logic [2:0] alu_exp[3];
        fn = '{6'b101010, 6'b100010, 6'b000111};
        alu_exp = '{3'b111, 3'b110, 3'b010};
        opcode = 6'b000000;
        for (int k = 0; k < 3; k++) begin
            funct = fn[k];
            exp_q.push_back(4'd0); exp_q.push_back(4'd1);
            exp_q.push_back((k < 2) ? 4'd5 : 4'd0);
            if (k < 2) exp_q.push_back(4'd0);
            for (int i = 0; exp_q.size() > 0; i++) begin
                drive(1'b1);
                exp = exp_q.pop_front();
                n_total++;
                if (state !== exp) begin n_bad++; $display("FAIL rtype_state f=%b cyc=%0d got=%0d want=%0d", funct, i, state, exp); end
                n_total++;
                if (illegal_op !== (k == 2 && i == 1))
                    begin n_bad++; $display("FAIL rtype_illegal f=%b cyc=%0d got=%b", funct, i, illegal_op); end
                if (exp == 4'd5) begin
                    n_total++;
                    if (alucont !== alu_exp[k] || alusrca !== 1'b1 || alusrcb !== 2'b00)
                        begin n_bad++; $display("FAIL rtype_alu f=%b got=%b want=%b srca=%b srcb=%b", funct, alucont, alu_exp[k], alusrca, alusrcb); end
                end
                if (exp_q.size() > 0) tick();
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [3:0] exp;
        logic [3:0] ex_st[3];
        logic [5:0] ops[3];
        logic       zs[3];
        ex_st = '{4'd7, 4'd7, 4'd8};
        ops   = '{6'b000100, 6'b000100, 6'b000010};
        zs    = '{1'b1, 1'b0, 1'b1};
        funct = 6'd0;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            zero   = zs[k];
            exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(ex_st[k]); exp_q.push_back(4'd0);
            while (exp_q.size() > 0) begin
                drive(1'b1);
                exp = exp_q.pop_front();
                n_total++;
                if (state !== exp) begin n_bad++; $display("FAIL br_state k=%0d got=%0d want=%0d", k, state, exp); end
                if (exp == 4'd7) begin
                    n_total++;
                    if (pc_write !== zs[k] || pc_src !== 2'b01 || alucont !== 3'b110)
                        begin n_bad++; $display("FAIL beq_ex zero=%b pc_write=%b pc_src=%b alu=%b", zs[k], pc_write, pc_src, alucont); end
                end
                if (exp == 4'd8) begin
                    n_total++;
                    if (pc_write !== 1'b1 || pc_src !== 2'b10)
                        begin n_bad++; $display("FAIL j_ex pc_write=%b pc_src=%b want 1 10", pc_write, pc_src); end
                end
                if (exp_q.size() > 0) tick();
            end
        end
    endtask

    task automatic test_reset_in_sbwr();
        logic [3:0] exp;
        opcode = 6'b101000; funct = 6'd0;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
        exp_q.push_back(4'd4); exp_q.push_back(4'd4); exp_q.push_back(4'd0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) rst_n = 1'b0;
            if (i == 5) rst_n = 1'b1;
            drive((i < 3) ? 1'b1 : 1'b0);
            exp = exp_q.pop_front();
            n_total++;
            if (state !== exp) begin n_bad++; $display("FAIL sb_state cyc=%0d got=%0d want=%0d", i, state, exp); end
            if (i == 3) begin
                n_total++;
                if (mem_req !== 1'b1 || iord !== 1'b1)
                    begin n_bad++; $display("FAIL sb_wr mem_req=%b iord=%b want 1 1", mem_req, iord); end
            end
            if (i >= 4) begin
                n_total++;
                if (mem_req !== 1'b1 || iord !== 1'b0 || alusrca !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0)
                    begin n_bad++; $display("FAIL sb_reset cyc=%0d mem_req=%b iord=%b srca=%b ir=%b pc=%b", i, mem_req, iord, alusrca, ir_write, pc_write); end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_illegal();
        logic [3:0] exp;
        opcode = 6'b111111; funct = 6'd0;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd0);
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? 1'b1 : 1'b0);
            exp = exp_q.pop_front();
            n_total++;
            if (state !== exp) begin n_bad++; $display("FAIL illegal_state cyc=%0d got=%0d want=%0d", i, state, exp); end
            n_total++;
            if (illegal_op !== (i == 1)) begin n_bad++; $display("FAIL illegal_pulse cyc=%0d got=%b want=%b", i, illegal_op, (i == 1)); end
            if (i < 2) tick();
        end
        force dut.r_state = 4'd12;
        #1;
        n_total++;
        if (state !== 4'd12 || mem_req !== 1'b0 || ir_write !== 1'b0 || illegal_op !== 1'b0 || alucont !== 3'b010)
            begin n_bad++; $display("FAIL bad_code_outputs state=%0d mem_req=%b ir=%b ill=%b alu=%b", state, mem_req, ir_write, illegal_op, alucont); end
        release dut.r_state;
        tick();
        drive(1'b0);
        n_total++;
        if (state !== 4'd0) begin n_bad++; $display("FAIL bad_code_recover got=%0d want=0", state); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops[8];
        logic [5:0]  fns[8];
        logic [3:0]  exst[8];
        logic [11:0] op;
        logic [3:0]  exp;
        logic        mr;
        int k, wf, wd;
        ops  = '{6'b100000, 6'b101000, 6'b000000, 6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b000000};
        fns  = '{6'd0, 6'd0, 6'b100000, 6'b100101, 6'd0, 6'd0, 6'd0, 6'b100100};
        exst = '{4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8, 4'd5};
        for (int n = 0; n < 10; n++) begin
            k  = $urandom_range(0, 7);
            wf = $urandom_range(0, 2);
            op = {ops[k], fns[k]};
            for (int j = 0; j < wf; j++) begin exp_q.push_back(4'd0); mr_q.push_back(1'b0); op_q.push_back(op); end
            exp_q.push_back(4'd0); mr_q.push_back(1'b1); op_q.push_back(op);
            exp_q.push_back(4'd1); mr_q.push_back(1'($urandom_range(0, 1))); op_q.push_back(op);
            if (k < 2) begin
                wd = $urandom_range(0, 3);
                exp_q.push_back(4'd2); mr_q.push_back(1'($urandom_range(0, 1))); op_q.push_back(op);
                for (int j = 0; j < wd; j++) begin exp_q.push_back(exst[k]); mr_q.push_back(1'b0); op_q.push_back(op); end
                exp_q.push_back(exst[k]); mr_q.push_back(1'b1); op_q.push_back(op);
            end else begin
                exp_q.push_back(exst[k]); mr_q.push_back(1'($urandom_range(0, 1))); op_q.push_back(op);
            end
        end
        exp_q.push_back(4'd0); mr_q.push_back(1'b0); op_q.push_back(12'd0);
        while (exp_q.size() > 0) begin
            op = op_q.pop_front();
            mr = mr_q.pop_front();
            opcode = op[11:6];
            funct  = op[5:0];
            zero   = 1'($urandom_range(0, 1));
            drive(mr);
            exp = exp_q.pop_front();
            n_total++;
            if (state !== exp) begin n_bad++; $display("FAIL b2b_state op=%b got=%0d want=%0d", opcode, state, exp); end
            if (exp == 4'd0) begin
                n_total++;
                if (ir_write !== mr) begin n_bad++; $display("FAIL b2b_fetch_ir got=%b want=%b", ir_write, mr); end
            end
            if (exp_q.size() > 0) tick();
        end
    endtask

    // watchdog
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // sequence and final report
    initial begin
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        tick();
        test_reset();
        test_addi();
        test_lb();
        test_rtype();
        test_branch_jump();
        test_reset_in_sbwr();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/main_controller.md
MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  synchronous active-low reset; sampled on rising clk.
REQ-004 opcode  input  6  instr[31:26] from the instruction register; stable from DECODE onward.
REQ-005 funct  input  6  instr[5:0] from the instruction register; stable from DECODE onward.
REQ-006 zero  input  1  ALU result == 0; used in BEQEX.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 state  output  4  current state code; feeds state_to_control decoding.
REQ-009 alucont  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 alusrca  output  1  1 = rdata1, 0 = pc.
REQ-011 alusrcb  output  2  00 = rdata2, 10 = sign-extended imm; 01/11 are never driven.
REQ-012 mem_req  output  1  memory access request.
REQ-013 iord  output  1  0 = instruction address (pc), 1 = data address (aluresult).
REQ-014 ir_write  output  1  load the instruction register.
REQ-015 pc_write  output  1  update pc.
REQ-016 pc_src  output  2  00 = pc+4, 01 = branch target, 10 = jump target.
REQ-017 illegal_op  output  1  one-cycle pulse for an unsupported opcode or funct.

Function
REQ-018 State codes SHALL be FETCH=0, DECODE=1, MEMADR=2, LBRD=3, SBWR=4, RTYPEEX=5, ADDIEX=6, BEQEX=7, JEX=8.
REQ-019 Codes 9-15 SHALL transition to FETCH on the next edge, with every output at its default value.
REQ-020 Defaults in every state unless overridden:
- alucont=010, alusrca=0, alusrcb=00, pc_src=00
- mem_req=0, iord=0, ir_write=0, pc_write=0, illegal_op=0
REQ-021 All outputs SHALL be combinational from state, with only these exceptions:
- ir_write and pc_write also depend on mem_ready.
- pc_write also depends on zero.
- illegal_op also depends on opcode/funct.
REQ-022 FETCH:
- mem_req=1, iord=0.
- While mem_ready=0: hold FETCH with ir_write=0 and pc_write=0.
- In the mem_ready=1 cycle: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
REQ-023 DECODE lasts exactly one cycle and dispatches on opcode:
- 100000 (LB) -> MEMADR
- 101000 (SB) -> MEMADR
- 000000 (R-type) -> RTYPEEX
- 001000 (ADDI) -> ADDIEX
- 000100 (BEQ) -> BEQEX
- 000010 (J) -> JEX
REQ-024 In DECODE, an opcode not listed in REQ-023, or opcode 000000 with funct not in {100000, 100010, 100100, 100101, 101010}, SHALL give illegal_op=1 for that cycle and a transition to FETCH; no write state is entered.
REQ-025 MEMADR: alusrca=1, alusrcb=10, alucont=010 for one cycle; next state LBRD if opcode=100000, else SBWR.
REQ-026 LBRD and SBWR:
- Hold alusrca=1, alusrcb=10, alucont=010, mem_req=1, iord=1.
- Stay in the state while mem_ready=0; go to FETCH on the cycle mem_ready=1.
REQ-027 RTYPEEX: alusrca=1, alusrcb=00 for one cycle, then FETCH. alucont by funct:
- 100000 -> 010
- 100010 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010 -> 111
REQ-028 ADDIEX: alusrca=1, alusrcb=10, alucont=010 for one cycle, then FETCH.
REQ-029 BEQEX: alusrca=1, alusrcb=00, alucont=110, pc_src=01, pc_write=zero for one cycle, then FETCH.
REQ-030 JEX: pc_write=1, pc_src=10 for one cycle, then FETCH.
REQ-031 Instruction latency in cycles, with W = number of mem_ready=0 cycles in the corresponding access:
- R-type, ADDI, BEQ, J: 3+W
- LB, SB: 4+W_fetch+W_data
REQ-032 mem_ready SHALL be ignored in every state other than FETCH, LBRD and SBWR.

Reset
REQ-033 When rst_n=0 at a rising edge, state SHALL become FETCH regardless of the current state, including mid-access in LBRD/SBWR or mid-stall in FETCH.
REQ-034 While rst_n=0, the outputs SHALL equal the FETCH values with ir_write=0 and pc_write=0, regardless of mem_ready.
REQ-035 The first fetch SHALL begin in the first cycle after rst_n returns to 1.

Verification
REQ-036 Reset, then ADDI (opcode 001000) with mem_ready=1 constant -> state sequence 0,1,6,0; ir_write=1 and pc_write=1 only in cycle 1; in state 6, alusrca=1, alusrcb=10, alucont=010.
REQ-037 LB with mem_ready low for 2 cycles in FETCH and 3 cycles in LBRD -> sequence 0,0,0,1,2,3,3,3,3,0; mem_req=1 and iord=1 throughout LBRD.
REQ-038 R-type with funct 101010, then funct 100010 -> alucont=111, then alucont=110, in state 5; funct 000111 -> illegal_op=1 in DECODE, next state 0, state 5 never entered.
REQ-039 BEQ with zero=1 -> pc_write=1, pc_src=01 in state 7; repeat with zero=0 -> pc_write=0; J -> pc_write=1, pc_src=10 in state 8.
REQ-040 rst_n=0 asserted while in SBWR with mem_ready=0 -> state=0 on the next edge, mem_req=1, iord=0, no further SBWR cycle.
REQ-041 Opcode 111111 -> illegal_op pulse of exactly 1 cycle, return to FETCH; a forced state code of 12 -> state=0 on the next edge.
